fft_frame_serializer: RTL and testbench

//  Consumer end of the FFT output vector interface. Captures packed 32-bin
//  Xk_vect_real/Xk_vect_imag frames and streams them one complex bin per clk1

---
 rtl/fft_frame_serializer_if.sv | 32 +++
 rtl/fft_frame_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_serializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_serializer_if.sv
// Frame-in / sample-out bundle of the FFT frame serializer.
// The slave side is the serializer; the master side is its environment.
interface fft_frame_serializer_if #(
  parameter int N    = 32,
  parameter int W    = 16,
  parameter int IDXW = 5
);
  logic [N*W-1:0]  Xk_vect_real;
  logic [N*W-1:0]  Xk_vect_imag;
  logic            frame_valid;
  logic            frame_ready;
  logic [W-1:0]    sample_real;
  logic [W-1:0]    sample_imag;
  logic [IDXW-1:0] sample_idx;
  logic            sample_valid;
  logic            sample_ready;
  logic            sop;
  logic            eop;
  logic            overflow;

  modport slave (
    input  Xk_vect_real, Xk_vect_imag, frame_valid, sample_ready,
    output frame_ready, sample_real, sample_imag, sample_idx,
           sample_valid, sop, eop, overflow
  );

  modport master (
    output Xk_vect_real, Xk_vect_imag, frame_valid, sample_ready,
    input  frame_ready, sample_real, sample_imag, sample_idx,
           sample_valid, sop, eop, overflow
  );
endinterface

// File: rtl/fft_frame_serializer.sv
// Captures packed FFT frames into a two-slot ping-pong buffer and streams them
// out one complex bin per clock over a valid/ready handshake.
module fft_frame_serializer #(
  parameter int N       = 32,
  parameter int W       = 16,
  parameter int IDXW    = 5,
  parameter bit BIT_REV = 1'b0
) (
  input  logic clk1,
  input  logic rst,
  fft_frame_serializer_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      slot_full_q, slot_full_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    real_q, real_d;
  logic [W-1:0]    imag_q, imag_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            overflow_q, overflow_d;
  logic [N*W-1:0]  buf_re_q [2];
  logic [N*W-1:0]  buf_re_d [2];
  logic [N*W-1:0]  buf_im_q [2];
  logic [N*W-1:0]  buf_im_d [2];

  logic            hs_s, eop_hs_s, cap_ok_s, next_rd_s, fresh_s;
  logic            start_s, adv_s, stop_s;
  logic [N*W-1:0]  first_re_s, first_im_s;

  function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] v);
    logic [IDXW-1:0] r;
    for (int i = 0; i < IDXW; i++) begin
      r[i] = v[IDXW-1-i];
    end
    return r;
  endfunction

  function automatic logic [IDXW-1:0] map_idx(input logic [IDXW-1:0] c);
    if (BIT_REV) begin
      return bitrev(c);
    end else begin
      return c;
    end
  endfunction

  // bin 0 sits at the MSB end of the packed vector
  function automatic logic [W-1:0] get_bin(input logic [N*W-1:0] vec, input logic [IDXW-1:0] k);
    return vec[W*(N-1-int'(k)) +: W];
  endfunction

  assign hs_s      = (state_q == STREAM) & bus.sample_ready;
  assign eop_hs_s  = hs_s & eop_q;
  // When both slots are full the write pointer aliases the read slot, so an
  // eop handshake in the same cycle frees exactly the slot we would write.
  assign cap_ok_s  = bus.frame_valid & (~slot_full_q[wr_ptr_q] | (eop_hs_s & (rd_ptr_q == wr_ptr_q)));
  assign next_rd_s = rd_ptr_q ^ eop_hs_s;
  assign fresh_s   = cap_ok_s & (wr_ptr_q == next_rd_s);
  assign first_re_s = fresh_s ? bus.Xk_vect_real : buf_re_q[next_rd_s];
  assign first_im_s = fresh_s ? bus.Xk_vect_imag : buf_im_q[next_rd_s];

  // Slot bookkeeping, FSM next state and next output sample
  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = next_rd_s;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    real_d      = real_q;
    imag_d      = imag_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    overflow_d  = overflow_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;
    start_s     = 1'b0;
    adv_s       = 1'b0;
    stop_s      = 1'b0;

    if (eop_hs_s) begin
      slot_full_d[rd_ptr_q] = 1'b0;
    end else begin
      slot_full_d = slot_full_q;
    end

    if (cap_ok_s) begin
      slot_full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = ~wr_ptr_q;
      buf_re_d[wr_ptr_q]    = bus.Xk_vect_real;
      buf_im_d[wr_ptr_q]    = bus.Xk_vect_imag;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (bus.frame_valid && !cap_ok_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      IDLE: begin
        start_s = slot_full_d[next_rd_s];
      end
      STREAM: begin
        if (hs_s && !eop_q) begin
          adv_s = 1'b1;
        end else if (eop_hs_s) begin
          if (slot_full_d[next_rd_s]) begin
            start_s = 1'b1;
          end else begin
            stop_s = 1'b1;
          end
        end else begin
          adv_s = 1'b0;
        end
      end
      default: begin
        stop_s = 1'b1;
      end
    endcase

    if (start_s) begin
      state_d = STREAM;
      cnt_d   = {IDXW{1'b0}};
      idx_d   = map_idx({IDXW{1'b0}});
      real_d  = get_bin(first_re_s, idx_d);
      imag_d  = get_bin(first_im_s, idx_d);
      sop_d   = 1'b1;
      eop_d   = (N == 1);
    end else if (adv_s) begin
      cnt_d  = cnt_q + IDXW'(1);
      idx_d  = map_idx(cnt_d);
      real_d = get_bin(buf_re_q[rd_ptr_q], idx_d);
      imag_d = get_bin(buf_im_q[rd_ptr_q], idx_d);
      sop_d  = 1'b0;
      eop_d  = (cnt_d == IDXW'(N-1));
    end else if (stop_s) begin
      state_d = IDLE;
      cnt_d   = {IDXW{1'b0}};
      idx_d   = {IDXW{1'b0}};
      real_d  = {W{1'b0}};
      imag_d  = {W{1'b0}};
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // Control state and registered sample outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_full_q <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= {IDXW{1'b0}};
      idx_q       <= {IDXW{1'b0}};
      real_q      <= {W{1'b0}};
      imag_q      <= {W{1'b0}};
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      overflow_q  <= overflow_d;
    end
  end

  // Frame storage; contents are qualified by the slot-full flags
  always_ff @(posedge clk1) begin
    buf_re_q <= buf_re_d;
    buf_im_q <= buf_im_d;
  end

  assign bus.frame_ready  = ~(slot_full_q[0] & slot_full_q[1]);
  assign bus.sample_valid = (state_q == STREAM);
  assign bus.sample_real  = real_q;
  assign bus.sample_imag  = imag_q;
  assign bus.sample_idx   = idx_q;
  assign bus.sop          = sop_q;
  assign bus.eop          = eop_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Self-checking bench: queue-based reference model for the natural-order
// instance, plus a table of expected bit-reversed indices for a second instance.
module tb_fft_frame_serializer;

  localparam int N = 32;
  localparam int W = 16;
  localparam int IDXW = 5;

  typedef struct {
    logic [W-1:0]    re;
    logic [W-1:0]    im;
    logic [IDXW-1:0] idx;
    logic            sop;
    logic            eop;
  } samp_t;

  typedef struct {
    int              pos;
    logic [IDXW-1:0] exp_idx;
  } br_vec_t;

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  fft_frame_serializer_if #(.N(N), .W(W), .IDXW(IDXW)) bus ();
  fft_frame_serializer_if #(.N(N), .W(W), .IDXW(IDXW)) bus_br ();

  fft_frame_serializer #(.N(N), .W(W), .IDXW(IDXW), .BIT_REV(1'b0)) dut (
    .clk1(clk1), .rst(rst), .bus(bus)
  );
  fft_frame_serializer #(.N(N), .W(W), .IDXW(IDXW), .BIT_REV(1'b1)) dut_br (
    .clk1(clk1), .rst(rst), .bus(bus_br)
  );

  samp_t exp_q[$];
  int    held;
  logic  ovf_m;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic make_frame(input int mode, output logic [N*W-1:0] re, output logic [N*W-1:0] im);
    for (int k = 0; k < N; k++) begin
      if (mode == 0) begin
        re[W*(N-k)-1 -: W] = W'(k);
        im[W*(N-k)-1 -: W] = W'(-k);
      end else begin
        re[W*(N-k)-1 -: W] = W'($urandom);
        im[W*(N-k)-1 -: W] = W'($urandom);
      end
    end
  endtask

  // One clock: update the model with what the edge will do, then compare.
  task automatic cycle(input logic fv, input logic [N*W-1:0] re, input logic [N*W-1:0] im,
                       input logic rdy, input logic do_rst);
    samp_t s;
    logic  eoph;
    bus.frame_valid  = fv;
    bus.Xk_vect_real = re;
    bus.Xk_vect_imag = im;
    bus.sample_ready = rdy;
    rst              = do_rst;
    if (do_rst) begin
      exp_q.delete();
      held  = 0;
      ovf_m = 1'b0;
    end else begin
      eoph = 1'b0;
      if (exp_q.size() > 0 && rdy) begin
        eoph = exp_q[0].eop;
        void'(exp_q.pop_front());
        if (eoph) held--;
      end
      if (fv) begin
        if (held < 2) begin
          held++;
          for (int c = 0; c < N; c++) begin
            s.idx = IDXW'(c);
            s.re  = re[W*(N-c)-1 -: W];
            s.im  = im[W*(N-c)-1 -: W];
            s.sop = (c == 0);
            s.eop = (c == N-1);
            exp_q.push_back(s);
          end
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    @(posedge clk1);
    #1;
    chk("sample_valid", 32'(bus.sample_valid), 32'(exp_q.size() > 0));
    chk("frame_ready", 32'(bus.frame_ready), 32'(held < 2));
    chk("overflow", 32'(bus.overflow), 32'(ovf_m));
    if (exp_q.size() > 0) begin
      chk("sample_idx", 32'(bus.sample_idx), 32'(exp_q[0].idx));
      chk("sample_real", 32'(bus.sample_real), 32'(exp_q[0].re));
      chk("sample_imag", 32'(bus.sample_imag), 32'(exp_q[0].im));
      chk("sop", 32'(bus.sop), 32'(exp_q[0].sop));
      chk("eop", 32'(bus.eop), 32'(exp_q[0].eop));
    end else begin
      chk("sop_idle", 32'(bus.sop), 32'd0);
      chk("eop_idle", 32'(bus.eop), 32'd0);
    end
    if (do_rst) begin
      chk("rst_real", 32'(bus.sample_real), 32'd0);
      chk("rst_imag", 32'(bus.sample_imag), 32'd0);
      chk("rst_idx", 32'(bus.sample_idx), 32'd0);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (bus.sample_valid === 1'b1 && n < bound) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 32'(bus.sample_valid), 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] fa_re, fa_im, fb_re, fb_im, fc_re, fc_im;
    br_vec_t        br_tab[9];
    logic [N-1:0]   seen;
    int             vcyc, n;

    br_tab[0] = '{0, 5'd0};  br_tab[1] = '{1, 5'd16}; br_tab[2] = '{2, 5'd8};
    br_tab[3] = '{3, 5'd24}; br_tab[4] = '{4, 5'd4};  br_tab[5] = '{5, 5'd20};
    br_tab[6] = '{6, 5'd12}; br_tab[7] = '{7, 5'd28}; br_tab[8] = '{31, 5'd31};

    bus_br.frame_valid  = 1'b0;
    bus_br.sample_ready = 1'b1;
    bus_br.Xk_vect_real = '0;
    bus_br.Xk_vect_imag = '0;
    held  = 0;
    ovf_m = 1'b0;

    // Reset
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // 1: ramp frame at full rate
    make_frame(0, fa_re, fa_im);
    cycle(1'b1, fa_re, fa_im, 1'b1, 1'b0);
    chk("t1_sop", 32'(bus.sop), 32'd1);
    drain(40);

    // 2: ready toggling; sample_valid must persist for 64 cycles
    cycle(1'b1, fa_re, fa_im, 1'b0, 1'b0);
    vcyc = 0;
    n    = 0;
    while (bus.sample_valid === 1'b1 && n < 200) begin
      vcyc++;
      cycle(1'b0, '0, '0, logic'(n % 2), 1'b0);
      n++;
    end
    chk("t2_valid_cycles", 32'(vcyc), 32'd64);

    // 3: two frames ten cycles apart
    make_frame(1, fa_re, fa_im);
    make_frame(1, fb_re, fb_im);
    cycle(1'b1, fa_re, fa_im, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, fb_re, fb_im, 1'b1, 1'b0);
    drain(80);

    // 4: stalled sink, three strobes, third dropped
    make_frame(1, fa_re, fa_im);
    make_frame(1, fb_re, fb_im);
    make_frame(1, fc_re, fc_im);
    cycle(1'b1, fa_re, fa_im, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, fb_re, fb_im, 1'b0, 1'b0);
    chk("t4_frame_ready", 32'(bus.frame_ready), 32'd0);
    cycle(1'b1, fc_re, fc_im, 1'b0, 1'b0);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (bus.sample_valid === 1'b1 && n < 200) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("t4_samples", 32'(n), 32'd64);

    // 6: reset in the middle of a frame (also clears overflow)
    make_frame(0, fa_re, fa_im);
    cycle(1'b1, fa_re, fa_im, 1'b1, 1'b0);
    n = 0;
    while (bus.sample_idx !== 5'd12 && n < 40) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("t6_reached_12", 32'(bus.sample_idx), 32'd12);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    chk("t6_rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("t6_rst_ready", 32'(bus.frame_ready), 32'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, fa_re, fa_im, 1'b1, 1'b0);
    chk("t6_restart_sop", 32'(bus.sop), 32'd1);
    chk("t6_restart_idx", 32'(bus.sample_idx), 32'd0);
    drain(40);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      make_frame(1, fa_re, fa_im);
      cycle(logic'($urandom_range(0, 29) == 0), fa_re, fa_im,
            logic'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain(200);

    // 5: bit-reversed instance, bin k real = k
    make_frame(0, fa_re, fa_im);
    bus_br.Xk_vect_real = fa_re;
    bus_br.Xk_vect_imag = fa_im;
    bus_br.frame_valid  = 1'b1;
    @(posedge clk1);
    #1;
    bus_br.frame_valid = 1'b0;
    seen = '0;
    for (int c = 0; c < N; c++) begin
      chk("t5_valid", 32'(bus_br.sample_valid), 32'd1);
      chk("t5_real_eq_idx", 32'(bus_br.sample_real), 32'(bus_br.sample_idx));
      chk("t5_sop", 32'(bus_br.sop), 32'(c == 0));
      chk("t5_eop", 32'(bus_br.eop), 32'(c == N-1));
      for (int t = 0; t < 9; t++) begin
        if (br_tab[t].pos == c) chk("t5_order", 32'(bus_br.sample_idx), 32'(br_tab[t].exp_idx));
      end
      seen[bus_br.sample_idx] = 1'b1;
      @(posedge clk1);
      #1;
    end
    chk("t5_all_bins", 32'(seen), 32'hFFFF_FFFF);
    chk("t5_done", 32'(bus_br.sample_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
